// File: rtl/fetch_controller_if.sv
// Bundle of the fetch controller's memory-side and decode-side signals.
// The controller takes the master view; the memory/decode environment takes the slave view.
interface fetch_controller_if;
  logic        start;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        halted;

  modport master (
    input  start, mem_inst, redirect_valid, redirect_target, inst_ready,
    output mem_addr, inst, inst_pc, inst_valid, halted
  );

  modport slave (
    output start, mem_inst, redirect_valid, redirect_target, inst_ready,
    input  mem_addr, inst, inst_pc, inst_valid, halted
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues word addresses to a one-cycle-latency memory,
// buffers responses in an in-order FIFO for decode, and stops after a HALT opcode.
module fetch_controller #(
  parameter logic [31:0] BOOT_ADDR   = 32'd0,
  parameter int          MEM_WORDS   = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  HALT_OPCODE = 8'h0F
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fetch_controller_if.master bus
);

  localparam logic [31:0] PC_MASK  = 32'(MEM_WORDS - 1);
  localparam logic [31:0] BOOT_PC  = BOOT_ADDR & PC_MASK;
  localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

  logic active;
  logic issue;
  logic push;
  logic pop;
  logic flush;
  logic capture_halt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    issue         = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    capture_halt  = 1'b0;
    active        = (state_q == S_FETCH) || (state_q == S_DRAIN);
    pop           = active && (count_q != '0) && bus.inst_ready;

    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = BOOT_PC;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (bus.redirect_valid) begin
          // A pop in this cycle is still a completed transfer; everything else is dropped.
          flush   = 1'b1;
          pc_d    = bus.redirect_target & PC_MASK;
          state_d = S_FETCH;
        end else begin
          push         = inflight_q;
          capture_halt = push && (bus.mem_inst[31:24] == HALT_OPCODE);
          if (capture_halt) begin
            state_d = S_DRAIN;
          end else if ((state_q == S_FETCH) &&
                       ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH)) begin
            issue = 1'b1;
          end
          // Nothing is pushed while draining, so the last entry is the HALT word.
          if ((state_q == S_DRAIN) && pop && (count_q == CNT_W'(1))) begin
            state_d = S_HALTED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = (pc_q + 32'd1) & PC_MASK;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= BOOT_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (wr_ptr_q == PTR_W'(i))) begin
          fifo_inst_q[i] <= bus.mem_inst;
          fifo_pc_q[i]   <= inflight_pc_q;
        end
      end
    end
  end

  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = active && (count_q != '0);
  assign bus.inst       = bus.inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign bus.inst_pc    = bus.inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle vector table for the straight run
// to HALT, plus hand sequences for stall, redirect, wrap, mid-stream reset and restart.
module tb_fetch_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] mem [1024];

  fetch_controller_if bus();

  fetch_controller #(
    .BOOT_ADDR  (32'd0),
    .MEM_WORDS  (1024),
    .FIFO_DEPTH (4),
    .HALT_OPCODE(8'h0F)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency instruction memory.
  always @(posedge clk) bus.mem_inst <= mem[bus.mem_addr[9:0]];

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_halted;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic s, input logic r, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic h, input logic [31:0] a);
    vec_t t;
    t.start = s; t.ready = r; t.exp_valid = v; t.exp_pc = pc;
    t.exp_inst = ins; t.exp_halted = h; t.exp_addr = a;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  // Applies inputs just after a rising edge and returns at the following falling edge.
  task automatic drive(input logic r, input logic s, input logic rdy,
                       input logic rv, input logic [31:0] rt);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.start           = s;
    bus.inst_ready      = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk1("rst_valid",  bus.inst_valid, 1'b0);
    chk1("rst_halted", bus.halted, 1'b0);
    chk ("rst_addr",   bus.mem_addr, 32'd0);
    chk ("rst_inst",   bus.inst, 32'd0);
    chk ("rst_pc",     bus.inst_pc, 32'd0);
  endtask

  task automatic chk_deliver(input string name, input logic [31:0] pc, input logic [31:0] ins);
    chk1({name, "_valid"}, bus.inst_valid, 1'b1);
    chk ({name, "_pc"},    bus.inst_pc, pc);
    chk ({name, "_inst"},  bus.inst, ins);
    $display("%s: inst_valid=%0b inst_pc=%0d inst=%h", name, bus.inst_valid, bus.inst_pc, bus.inst);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'hB000_0000 | 32'(a);
    for (int a = 0; a < 9; a++)    mem[a] = 32'hA000_0000 | 32'(a);
    mem[9] = 32'h0F00_0000;

    // Straight run: start in cycle 0, first delivery cycle 3, HALT word at pc 9.
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 0, 32'h0,          1'b0, 0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 0, 32'h0,          1'b0, 0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 0, 32'h0,          1'b0, 1);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 0, 32'hA000_0000,  1'b0, 2);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1, 32'hA000_0001,  1'b0, 3);
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 2, 32'hA000_0002,  1'b0, 4);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 3, 32'hA000_0003,  1'b0, 5);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 4, 32'hA000_0004,  1'b0, 6);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 5, 32'hA000_0005,  1'b0, 7);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 6, 32'hA000_0006,  1'b0, 8);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 7, 32'hA000_0007,  1'b0, 9);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 8, 32'hA000_0008,  1'b0, 10);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 9, 32'h0F00_0000,  1'b0, 10);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 0, 32'h0,          1'b1, 10);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 0, 32'h0,          1'b1, 10);

    do_reset();
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, vecs[c].start, vecs[c].ready, 1'b0, 32'd0);
      chk1($sformatf("run_c%0d_valid", c),  bus.inst_valid, vecs[c].exp_valid);
      chk1($sformatf("run_c%0d_halted", c), bus.halted, vecs[c].exp_halted);
      chk ($sformatf("run_c%0d_addr", c),   bus.mem_addr, vecs[c].exp_addr);
      if (vecs[c].exp_valid) begin
        chk($sformatf("run_c%0d_pc", c),   bus.inst_pc, vecs[c].exp_pc);
        chk($sformatf("run_c%0d_inst", c), bus.inst, vecs[c].exp_inst);
      end
      $display("run cycle %0d: inst_valid=%0b inst_pc=%0d halted=%0b mem_addr=%0d",
               c, bus.inst_valid, bus.inst_pc, bus.halted, bus.mem_addr);
    end

    // HALTED ignores redirect, then start refetches from BOOT_ADDR.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk1("halt_hold", bus.halted, 1'b1);
    chk ("halt_noredir_addr", bus.mem_addr, 32'd10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("restart_halted", bus.halted, 1'b0);
    chk ("restart_addr", bus.mem_addr, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("restart_first", 32'd0, 32'hA000_0000);

    // Stall: decode not ready for 10 cycles after start; FIFO fills to 4 and issue stops.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      if (c >= 5) chk($sformatf("stall_c%0d_addr", c), bus.mem_addr, 32'd4);
    end
    chk_deliver("stall_head", 32'd0, 32'hA000_0000);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      chk_deliver($sformatf("release_%0d", k), 32'(k), 32'hA000_0000 | 32'(k));
    end

    // Redirect to 7 while pc 2,3 are buffered and 4 is in flight.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int c = 1; c <= 4; c++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_deliver("pre_redir", 32'd2, 32'hA000_0002);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd7);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("redir_c7_valid", bus.inst_valid, 1'b0);
    chk ("redir_c7_addr", bus.mem_addr, 32'd7);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("redir_c8_valid", bus.inst_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("redir_first", 32'd7, 32'hA000_0007);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("redir_second", 32'd8, 32'hA000_0008);

    // Redirect target beyond memory size wraps; start while fetching is ignored.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0001_03FF);
    chk1("wrap_c2_valid", bus.inst_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk ("wrap_c3_addr", bus.mem_addr, 32'd1023);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk ("wrap_c4_addr", bus.mem_addr, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("wrap_1023", 32'd1023, 32'hB000_03FF);
    chk ("start_ignored_addr", bus.mem_addr, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("wrap_0", 32'd0, 32'hA000_0000);

    // Reset asserted while an instruction is being presented.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int c = 1; c <= 4; c++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("pre_reset", 32'd2, 32'hA000_0002);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("midrst_valid",  bus.inst_valid, 1'b0);
    chk1("midrst_halted", bus.halted, 1'b0);
    chk ("midrst_addr",   bus.mem_addr, 32'd0);
    chk ("midrst_inst",   bus.inst, 32'd0);
    chk ("midrst_pc",     bus.inst_pc, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk ("idle_noredir_addr", bus.mem_addr, 32'd0);
    chk1("idle_valid", bus.inst_valid, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("refetch_first", 32'd0, 32'hA000_0000);

    // Redirect in the same cycle the HALT word is captured: no drain, fetch continues.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int c = 1; c <= 10; c++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'd20);
    chk_deliver("hr_c11", 32'd8, 32'hA000_0008);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("hr_c12_valid",  bus.inst_valid, 1'b0);
    chk1("hr_c12_halted", bus.halted, 1'b0);
    chk ("hr_c12_addr",   bus.mem_addr, 32'd20);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk1("hr_c13_valid",  bus.inst_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("hr_target", 32'd20, 32'hB000_0014);
    chk1("hr_c14_halted", bus.halted, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk_deliver("hr_next", 32'd21, 32'hB000_0015);
    chk1("hr_c15_halted", bus.halted, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Parameters
REQ-001 SHALL have parameter BOOT_ADDR, default 0, word address fetched first after start.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, instruction memory depth (power of 2); PC wraps modulo MEM_WORDS.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (legal >= 2), capacity of the fetched-instruction buffer.
REQ-004 SHALL have parameter HALT_OPCODE, default 8'h0F, matched against instruction bits [31:24].

Interface
REQ-005 Clk  in  1  sole clock, all state updates on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins fetching at BOOT_ADDR from IDLE or HALTED.
REQ-008 mem_addr  out  32  word address to instruction memory; memory samples it at the rising edge and returns data the next cycle.
REQ-009 mem_inst  in  32  memory read data, valid the cycle after the address was sampled.
REQ-010 redirect_valid  in  1  branch/jump redirect request, one-cycle pulse.
REQ-011 redirect_target  in  32  new word address, used modulo MEM_WORDS.
REQ-012 inst  out  32  head instruction presented to decode.
REQ-013 inst_pc  out  32  word address of inst.
REQ-014 inst_valid  out  1  inst/inst_pc valid.
REQ-015 inst_ready  in  1  decode accepts; transfer when inst_valid && inst_ready.
REQ-016 halted  out  1  high while in HALTED.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, HALTED.
REQ-018 IDLE: no issue; start -> FETCH with pc=BOOT_ADDR; redirect ignored.
REQ-019 FETCH: issue pc when fifo_count + inflight < FIFO_DEPTH; issue drives mem_addr=pc, sets inflight with inflight_pc=pc, pc <= (pc+1) mod MEM_WORDS.
REQ-020 mem_addr SHALL equal pc combinationally; non-issue cycles set no inflight entry, data discarded.
REQ-021 Response of an issue in cycle N SHALL be written to the FIFO at the end of N+1 with its PC; inst_valid earliest in N+2.
REQ-022 With FIFO_DEPTH >= 3 and inst_ready held high, one instruction per cycle SHALL be delivered after the 2-cycle fill.
REQ-023 FIFO SHALL be in-order; push and pop in the same cycle allowed, including at full (pop frees slot first).
REQ-024 When a captured word has [31:24]==HALT_OPCODE: it is pushed and delivered normally; issuing stops; any later in-flight response discarded; state -> DRAIN.
REQ-025 DRAIN: no issue; when the HALT word is popped and FIFO is empty -> HALTED.
REQ-026 HALTED: halted=1, no issue, inst_valid=0, redirect ignored; start -> FETCH at BOOT_ADDR.
REQ-027 redirect_valid in FETCH or DRAIN SHALL: flush FIFO, discard in-flight response, set pc=target mod MEM_WORDS, enter FETCH; first issue of target in the next cycle; no issue in the redirect cycle.
REQ-028 A transfer occurring in the redirect cycle SHALL count as consumed; remaining entries are dropped.
REQ-029 Redirect has priority over halt detection in the same cycle (halt word dropped).
REQ-030 start while in FETCH or DRAIN SHALL be ignored.
REQ-031 inst/inst_pc SHALL be stable while inst_valid && !inst_ready.

Reset
REQ-032 Reset SHALL force IDLE, pc=BOOT_ADDR, mem_addr=BOOT_ADDR, inst=0, inst_pc=0, inst_valid=0, halted=0, FIFO empty, inflight=0, overriding all other inputs including mid-fetch.

Verification
REQ-033 Mem[0..9] preloaded, last word 32'h0F000000; start cycle 0, inst_ready=1 -> inst_pc 0..9 on consecutive cycles starting cycle 3, no pc>9 delivered, halted=1 cycle after pc 9 transfer.
REQ-034 inst_ready=0 for 10 cycles after start -> exactly FIFO_DEPTH entries buffered, no more issues, pc 0..3 delivered in order, none lost or duplicated on release.
REQ-035 Redirect to 7 while pc 2,3,4 in flight/buffered -> next delivered inst_pc=7, two cycles after first issue of 7; 2,3,4 never valid afterwards.
REQ-036 Redirect target 1023 -> inst_pc 1023 then 0 (wrap).
REQ-037 Reset asserted mid-stream with inst_valid=1 -> next cycle all outputs at reset values, IDLE; fresh start refetches from 0.
REQ-038 Redirect in same cycle HALT word is captured -> no DRAIN, halted stays 0, fetch continues at target.
